// File: rtl/chunked_magnitude_comparator_pkg.sv
// Shared types for the chunked magnitude comparator: FSM states and one-hot result codes.
// Optional build macro SIGNED_CMP_EN is consumed by the top, not here.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam logic [2:0] CMP_EQ = 3'b001;
  localparam logic [2:0] CMP_GT = 3'b010;
  localparam logic [2:0] CMP_LT = 3'b100;

  function automatic logic [2:0] encode_result(input logic decided, input logic gt, input logic lt);
    logic [2:0] res;
    res = '0;
    if (!decided)  res = CMP_EQ;
    else if (gt)   res = CMP_GT;
    else if (lt)   res = CMP_LT;
    return res;
  endfunction

endpackage

// File: rtl/chunked_magnitude_comparator_if.sv
// Beat-streaming bus between an operand source (master) and the comparator (slave).
interface chunked_magnitude_comparator_if #(
  parameter int unsigned CHUNK_W = 8
) ();

  logic               start;
  logic               in_valid;
  logic               in_ready;
  logic [CHUNK_W-1:0] a_chunk;
  logic [CHUNK_W-1:0] b_chunk;
  logic               busy;
  logic               done;
  logic               eq;
  logic               gt;
  logic               lt;

  modport master (
    output start, in_valid, a_chunk, b_chunk,
    input  in_ready, busy, done, eq, gt, lt
  );

  modport slave (
    input  start, in_valid, a_chunk, b_chunk,
    output in_ready, busy, done, eq, gt, lt
  );

endinterface

// File: rtl/chunked_magnitude_comparator_chunk_cmp.sv
// Combinational compare of one chunk: XNOR equality and MSB-first greater-than scan.
// is_signed inverts the MSB of both operands so two's-complement ordering falls out of the unsigned scan.
module chunk_cmp #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         is_signed,
  output logic         eq,
  output logic         gt,
  output logic         lt
);

  logic [W-1:0] a_m;
  logic [W-1:0] b_m;
  logic         found;

  assign eq = &(a ~^ b);
  assign lt = ~eq & ~gt;

  always_comb begin
    a_m        = a;
    b_m        = b;
    a_m[W-1]   = a[W-1] ^ is_signed;
    b_m[W-1]   = b[W-1] ^ is_signed;
    gt         = 1'b0;
    found      = 1'b0;
    for (int unsigned i = 0; i < W; i++) begin
      if (!found && (a_m[W-1-i] != b_m[W-1-i])) begin
        gt    = a_m[W-1-i];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/chunked_magnitude_comparator.sv
// Sequential A?B comparator fed MSB chunk first; registered one-hot eq/gt/lt and a done pulse.
// Define SIGNED_CMP_EN to treat full operands as two's complement (first beat compared signed).
module chunked_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int unsigned CHUNK_W    = 8,
  parameter int unsigned NUM_CHUNKS = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  chunked_magnitude_comparator_if.slave  bus
);

  localparam int unsigned     CNT_W = $clog2(NUM_CHUNKS) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_CHUNKS - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             decided_q;
  logic             gt_r_q;
  logic             lt_r_q;
  logic             in_ready_q;
  logic             busy_q;
  logic             done_q;
  logic [2:0]       result_q;

  logic             decided_d;
  logic             gt_r_d;
  logic             lt_r_d;
  logic             c_eq, c_gt, c_lt;
  logic             is_signed;
  logic             accept;
  logic             start_ok;

`ifdef SIGNED_CMP_EN
  assign is_signed = (cnt_q == '0);
`else
  assign is_signed = 1'b0;
`endif

  chunk_cmp #(.W(CHUNK_W)) u_chunk_cmp (
    .a         (bus.a_chunk),
    .b         (bus.b_chunk),
    .is_signed (is_signed),
    .eq        (c_eq),
    .gt        (c_gt),
    .lt        (c_lt)
  );

  // in_ready_q is only ever high in RUN, so it doubles as the state qualifier.
  assign accept   = bus.in_valid && in_ready_q;
  assign start_ok = bus.start && (state_q != RUN);

  // First unequal chunk decides; later beats only advance the counter.
  always_comb begin
    decided_d = decided_q;
    gt_r_d    = gt_r_q;
    lt_r_d    = lt_r_q;
    if (accept && !decided_q && !c_eq) begin
      decided_d = 1'b1;
      gt_r_d    = c_gt;
      lt_r_d    = c_lt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      decided_q  <= 1'b0;
      gt_r_q     <= 1'b0;
      lt_r_q     <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (start_ok) begin
        state_q    <= RUN;
        cnt_q      <= '0;
        decided_q  <= 1'b0;
        gt_r_q     <= 1'b0;
        lt_r_q     <= 1'b0;
        result_q   <= '0;
        in_ready_q <= 1'b1;
        busy_q     <= 1'b1;
      end else begin
        case (state_q)
          IDLE: ;
          RUN: begin
            if (accept) begin
              decided_q <= decided_d;
              gt_r_q    <= gt_r_d;
              lt_r_q    <= lt_r_d;
              if (cnt_q == LAST) begin
                state_q    <= DONE;
                done_q     <= 1'b1;
                in_ready_q <= 1'b0;
                busy_q     <= 1'b0;
                result_q   <= encode_result(decided_d, gt_r_d, lt_r_d);
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.eq       = |(result_q & CMP_EQ);
  assign bus.gt       = |(result_q & CMP_GT);
  assign bus.lt       = |(result_q & CMP_LT);

endmodule

// File: tb/tb_chunked_magnitude_comparator.sv
// Randomized self-checking bench for chunked_magnitude_comparator (CHUNK_W=8, NUM_CHUNKS=4).
module tb_chunked_magnitude_comparator;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  chunked_magnitude_comparator_if #(.CHUNK_W(8)) bus ();

  chunked_magnitude_comparator #(
    .CHUNK_W    (8),
    .NUM_CHUNKS (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Whole-operand reference: {lt, gt, eq}
  function automatic logic [2:0] ref_cmp(input logic [31:0] a, input logic [31:0] b);
`ifdef SIGNED_CMP_EN
    if ($signed(a) > $signed(b)) return 3'b010;
    if ($signed(a) < $signed(b)) return 3'b100;
`else
    if (a > b) return 3'b010;
    if (a < b) return 3'b100;
`endif
    return 3'b001;
  endfunction

  task automatic run_cmp(input logic [31:0] a, input logic [31:0] b, input int gap_pct,
                         input bit poke_start, input bit valid_with_start);
    int   edges;
    int   beat;
    bit   accepted;
    logic [2:0] exp;
    exp = ref_cmp(a, b);
    bus.start    = 1'b1;
    bus.in_valid = valid_with_start;
    bus.a_chunk  = 8'hFF;
    bus.b_chunk  = 8'h00;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    edges = 1;
    check_val("busy_run", bus.busy, 1);
    check_val("res_cleared", {bus.lt, bus.gt, bus.eq}, 0);
    beat = 0;
    while (beat < 4 && edges < 200) begin
      check_val("in_ready_run", bus.in_ready, 1);
      check_val("done_early", bus.done, 0);
      bus.in_valid = ($urandom_range(99) >= gap_pct);
      bus.a_chunk  = a[8*(3-beat) +: 8];
      bus.b_chunk  = b[8*(3-beat) +: 8];
      bus.start    = poke_start && (beat == 1);
      accepted     = bus.in_valid;
      @(posedge clk); #1;
      edges++;
      bus.start = 1'b0;
      if (accepted) beat++;
    end
    bus.in_valid = 1'b0;
    if (beat < 4) check_val("beat_timeout", beat, 4);
    check_val("done_pulse", bus.done, 1);
    check_val("busy_done", bus.busy, 0);
    check_val("result", {bus.lt, bus.gt, bus.eq}, exp);
    if (gap_pct == 0) check_val("latency", edges, 5);
  endtask

  task automatic idle_check(input logic [2:0] exp);
    @(posedge clk); #1;
    check_val("done_cleared", bus.done, 0);
    check_val("result_hold", {bus.lt, bus.gt, bus.eq}, exp);
  endtask

  initial begin
    logic [31:0] a, b;
    int          k;
    n_vec = 0;
    n_err = 0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.a_chunk  = '0;
    bus.b_chunk  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("reset_outs", {bus.in_ready, bus.busy, bus.done, bus.lt, bus.gt, bus.eq}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_cmp(32'h1234_5678, 32'h1234_5678, 0, 0, 0);
    idle_check(3'b001);
    run_cmp(32'h1234_5679, 32'h1234_5678, 0, 0, 0);
    idle_check(3'b010);
    run_cmp(32'h0000_0000, 32'h0100_0000, 0, 0, 0);
    idle_check(3'b100);
    run_cmp(32'hFFFF_0000, 32'hFFFE_FFFF, 50, 0, 0);
    idle_check(3'b010);
    run_cmp(32'h8000_0000, 32'h7FFF_FFFF, 0, 0, 0);
    idle_check(ref_cmp(32'h8000_0000, 32'h7FFF_FFFF));
    // Beat offered alongside start must be dropped
    run_cmp(32'h0000_0000, 32'h0000_0000, 0, 0, 1);
    idle_check(3'b001);
    // Back-to-back from DONE, with a start pulse during RUN
    run_cmp(32'hA000_0001, 32'hA000_0000, 0, 0, 0);
    run_cmp(32'h0000_00FE, 32'h0000_00FF, 0, 1, 0);
    idle_check(3'b100);

    // Asynchronous reset after two beats
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.a_chunk  = 8'h55;
    bus.b_chunk  = 8'h11;
    repeat (2) @(posedge clk);
    #2;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_val("async_rst", {bus.in_ready, bus.busy, bus.done, bus.lt, bus.gt, bus.eq}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_cmp(32'h0, 32'h0, 0, 0, 0);
    idle_check(3'b001);

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(2))
        0:       b = $urandom;
        1:       b = a;
        default: begin
          k = $urandom_range(3);
          b = a ^ (32'($urandom_range(255, 1)) << (8 * k));
        end
      endcase
      run_cmp(a, b, ($urandom_range(1) == 1) ? 50 : 0, 0, 0);
      if ($urandom_range(1) == 1) idle_check(ref_cmp(a, b));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
